// File: rtl/sdn_parser_pkg.sv
// sdn_parser shared definitions: port-count limits
// and rx arbiter FSM state encodings.
package sdn_parser_pkg;

  localparam int SDN_NUM_PORTS_MIN = 2;
  localparam int SDN_NUM_PORTS_MAX = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } rx_arb_state_e;

endpackage

// File: rtl/sdn_rr_arbiter.sv
// Combinational round-robin pick: first requester
// after i_last_grant in ascending cyclic order.
module sdn_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last_grant,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  logic          w_found;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = IW'((int'(i_last_grant) + i) % N);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdn_parser_rx_arbiter.sv
// Packet-granular round-robin merge of N AXI-Stream
// rx ports into one registered parser stream.
module sdn_parser_rx_arbiter
  import sdn_parser_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int PRS_RX_DATA_W = 512,
  parameter int PRS_RX_KEEP_W = PRS_RX_DATA_W / 8
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [NUM_PORTS-1:0]               s_axis_rx_tvalid_i,
  input  logic [NUM_PORTS*PRS_RX_DATA_W-1:0] s_axis_rx_tdata_i,
  input  logic [NUM_PORTS*PRS_RX_KEEP_W-1:0] s_axis_rx_tkeep_i,
  input  logic [NUM_PORTS-1:0]               s_axis_rx_tlast_i,
  output logic [NUM_PORTS-1:0]               s_axis_rx_tready_o,
  output logic                               parser_axis_rx_tvalid_o,
  output logic [PRS_RX_DATA_W-1:0]           parser_axis_rx_tdata_o,
  output logic [PRS_RX_KEEP_W-1:0]           parser_axis_rx_tkeep_o,
  output logic                               parser_axis_rx_tlast_o,
  input  logic                               parser_axis_rx_tready_i,
  output logic [NUM_PORTS-1:0]               grant_o,
  output logic                               busy_o
);

  localparam int IW = $clog2(NUM_PORTS);

  if (NUM_PORTS < SDN_NUM_PORTS_MIN ||
      NUM_PORTS > SDN_NUM_PORTS_MAX) begin : g_np_chk
    $error("NUM_PORTS out of range");
  end

  rx_arb_state_e              r_state;
  rx_arb_state_e              w_next;
  logic [NUM_PORTS-1:0]       r_grant;
  logic [NUM_PORTS-1:0]       w_arb_gnt;
  logic [IW-1:0]              r_gidx;
  logic [IW-1:0]              r_last;
  logic [IW-1:0]              w_arb_idx;
  logic                       r_tvalid;
  logic                       r_tlast;
  logic [PRS_RX_DATA_W-1:0]   r_tdata;
  logic [PRS_RX_KEEP_W-1:0]   r_tkeep;
  logic                       w_any_req;
  logic                       w_sel_valid;
  logic                       w_sel_last;
  logic [PRS_RX_DATA_W-1:0]   w_sel_data;
  logic [PRS_RX_KEEP_W-1:0]   w_sel_keep;
  logic                       w_out_rdy;
  logic                       w_accept;
  logic                       w_eop;

  sdn_rr_arbiter #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_rr (
    .i_req        (s_axis_rx_tvalid_i),
    .i_last_grant (r_last),
    .o_gnt        (w_arb_gnt),
    .o_gnt_idx    (w_arb_idx)
  );

  assign w_any_req   = |s_axis_rx_tvalid_i;
  assign w_sel_valid = s_axis_rx_tvalid_i[r_gidx];
  assign w_sel_last  = s_axis_rx_tlast_i[r_gidx];
  assign w_sel_data  =
    s_axis_rx_tdata_i[r_gidx*PRS_RX_DATA_W +: PRS_RX_DATA_W];
  assign w_sel_keep  =
    s_axis_rx_tkeep_i[r_gidx*PRS_RX_KEEP_W +: PRS_RX_KEEP_W];

  // output register can take a beat when empty or draining
  assign w_out_rdy = ~r_tvalid | parser_axis_rx_tready_i;
  assign w_accept  = (r_state == ST_XFER) & w_sel_valid & w_out_rdy;
  assign w_eop     = w_accept & w_sel_last;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_any_req) w_next = ST_XFER;
      ST_XFER: if (w_eop)     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(NUM_PORTS - 1);
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_any_req) begin
        r_grant <= w_arb_gnt;
        r_gidx  <= w_arb_idx;
      end else if (w_eop) begin
        r_grant <= '0;
        r_last  <= r_gidx;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
    end else if (w_accept) begin
      r_tvalid <= 1'b1;
      r_tlast  <= w_sel_last;
      r_tdata  <= w_sel_data;
      r_tkeep  <= w_sel_keep;
    end else if (parser_axis_rx_tready_i) begin
      r_tvalid <= 1'b0;
    end
  end

  assign s_axis_rx_tready_o = (r_state == ST_XFER) ?
    (r_grant & {NUM_PORTS{w_out_rdy}}) : '0;

  assign parser_axis_rx_tvalid_o = r_tvalid;
  assign parser_axis_rx_tdata_o  = r_tdata;
  assign parser_axis_rx_tkeep_o  = r_tkeep;
  assign parser_axis_rx_tlast_o  = r_tlast;
  assign grant_o                 = r_grant;
  assign busy_o                  = (r_state == ST_XFER) | r_tvalid;

endmodule

// File: tb/tb_sdn_parser_rx_arbiter.sv
// Directed bench for sdn_parser_rx_arbiter: packet sources
// per port, output beat log, hand-computed expectations.
module tb_sdn_parser_rx_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int KW = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic [NP-1:0]    s_tvalid;
  logic [NP*DW-1:0] s_tdata;
  logic [NP*KW-1:0] s_tkeep;
  logic [NP-1:0]    s_tlast;
  logic [NP-1:0]    s_tready;
  logic             p_tvalid;
  logic [DW-1:0]    p_tdata;
  logic [KW-1:0]    p_tkeep;
  logic             p_tlast;
  logic             p_tready_i;
  logic [NP-1:0]    grant;
  logic             busy;

  sdn_parser_rx_arbiter #(
    .NUM_PORTS     (NP),
    .PRS_RX_DATA_W (DW),
    .PRS_RX_KEEP_W (KW)
  ) dut (
    .clk                     (clk),
    .resetn                  (resetn),
    .s_axis_rx_tvalid_i      (s_tvalid),
    .s_axis_rx_tdata_i       (s_tdata),
    .s_axis_rx_tkeep_i       (s_tkeep),
    .s_axis_rx_tlast_i       (s_tlast),
    .s_axis_rx_tready_o      (s_tready),
    .parser_axis_rx_tvalid_o (p_tvalid),
    .parser_axis_rx_tdata_o  (p_tdata),
    .parser_axis_rx_tkeep_o  (p_tkeep),
    .parser_axis_rx_tlast_o  (p_tlast),
    .parser_axis_rx_tready_i (p_tready_i),
    .grant_o                 (grant),
    .busy_o                  (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int npk[NP];
  int plen[NP];
  int bt[NP];
  int pk[NP];
  bit hold[NP];

  logic [36:0]   lg[$];
  logic [NP-1:0] gq[$];
  int            gcyc[$];
  logic [NP-1:0] prevg = '0;
  logic          pv_stall = 1'b0;
  logic [DW-1:0] pv_data = '0;
  int cyc = 0;
  int n_unstable = 0;
  int n_leak = 0;
  int n_stall = 0;
  int n_lastcyc = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bdat(int p, int k, int b);
    return {8'(p), 8'(k), 8'(b), 8'hA5};
  endfunction

  function automatic logic [36:0] ent(int p, int k, int b, int len);
    logic l;
    l = (b == len - 1);
    return {l, l ? 4'h3 : 4'hF, bdat(p, k, b)};
  endfunction

  function automatic logic [63:0] lgat(int i);
    return (i < lg.size()) ? 64'(lg[i]) : '1;
  endfunction

  function automatic logic [63:0] gat(int i);
    return (i < gq.size()) ? 64'(gq[i]) : '1;
  endfunction

  function automatic bit pending();
    bit r;
    r = 1'b0;
    for (int p = 0; p < NP; p++) if (npk[p] > 0) r = 1'b1;
    return r;
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      s_tvalid[p] = (npk[p] > 0) && !hold[p];
      s_tdata[p*DW +: DW] = bdat(p, pk[p], bt[p]);
      s_tkeep[p*KW +: KW] = (bt[p] == plen[p] - 1) ? 4'h3 : 4'hF;
      s_tlast[p] = (bt[p] == plen[p] - 1);
    end
  endtask

  task automatic clr();
    for (int p = 0; p < NP; p++) begin
      npk[p] = 0; plen[p] = 1; bt[p] = 0; pk[p] = 0; hold[p] = 0;
    end
    lg.delete(); gq.delete(); gcyc.delete();
    prevg = '0;
    drive();
  endtask

  task automatic step();
    logic [NP-1:0] hs;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    if (p_tvalid && p_tready_i) lg.push_back({p_tlast, p_tkeep, p_tdata});
    if (pv_stall && !(p_tvalid && p_tdata == pv_data)) n_unstable++;
    pv_stall = p_tvalid && !p_tready_i;
    pv_data  = p_tdata;
    if (p_tvalid && !p_tready_i) n_stall++;
    if (p_tvalid && p_tlast) n_lastcyc++;
    if ((s_tready & ~grant) != '0) n_leak++;
    if (grant != '0 && grant != prevg) begin
      gq.push_back(grant);
      gcyc.push_back(cyc);
    end
    prevg = grant;
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        bt[p]++;
        if (bt[p] == plen[p]) begin
          bt[p] = 0; pk[p]++; npk[p]--;
        end
      end
    end
    drive();
  endtask

  task automatic run(string tag, int max);
    int n;
    n = 0;
    while ((pending() || busy) && n < max) begin
      step();
      n++;
    end
    chk(tag, 64'(n < max), 1);
  endtask

  initial begin
    int n;
    bit en;
    bit done;
    int t;
    int hc;
    logic [3:0] pat;

    resetn = 1'b0;
    p_tready_i = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(p_tvalid), 0);
    chk("rst_tlast", 64'(p_tlast), 0);
    chk("rst_tdata", 64'(p_tdata), 0);
    chk("rst_tkeep", 64'(p_tkeep), 0);
    chk("rst_grant", 64'(grant), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_tready", 64'(s_tready), 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // four ports, two 2-beat packets each
    clr();
    for (int p = 0; p < NP; p++) begin
      npk[p] = 2; plen[p] = 2;
    end
    drive();
    run("rr_done", 200);
    chk("rr_ngnt", 64'(gq.size()), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rr_gnt%0d", i), gat(i), 64'(1 << (i % 4)));
    for (int i = 1; i < gcyc.size(); i++)
      chk($sformatf("rr_gap%0d", i), 64'(gcyc[i] - gcyc[i-1]), 3);
    chk("rr_nbeat", 64'(lg.size()), 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("rr_beat%0d", i), lgat(i),
          64'(ent((i / 2) % 4, i / 8, i % 2, 2)));

    // port 1 requests while port 2 is mid-packet
    clr();
    npk[2] = 1; plen[2] = 5;
    drive();
    en = 1'b0;
    n = 0;
    while ((pending() || busy) && n < 200) begin
      step();
      n++;
      if (!en && bt[2] == 2) begin
        npk[1] = 1; plen[1] = 1; en = 1'b1;
        drive();
      end
    end
    chk("hold_done", 64'(n < 200), 1);
    chk("hold_ngnt", 64'(gq.size()), 2);
    chk("hold_gnt0", gat(0), 4);
    chk("hold_gnt1", gat(1), 2);
    chk("hold_nbeat", 64'(lg.size()), 6);
    for (int i = 0; i < 5; i++)
      chk($sformatf("hold_beat%0d", i), lgat(i), 64'(ent(2, 0, i, 5)));
    chk("hold_beat5", lgat(5), 64'(ent(1, 0, 0, 1)));

    // parser backpressure 1,0,0,1 during a 4-beat packet
    clr();
    npk[0] = 1; plen[0] = 4;
    drive();
    pat = 4'b1001;
    t = 0;
    n_stall = 0;
    n = 0;
    while ((pending() || busy) && n < 200) begin
      step();
      n++;
      if (grant != '0 || t > 0) begin
        p_tready_i = (t < 4) ? pat[t] : 1'b1;
        t++;
      end
    end
    p_tready_i = 1'b1;
    chk("bp_done", 64'(n < 200), 1);
    chk("bp_nstall", 64'(n_stall), 2);
    chk("bp_nbeat", 64'(lg.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_beat%0d", i), lgat(i), 64'(ent(0, 0, i, 4)));

    // single-beat packets on port 3
    clr();
    npk[3] = 3; plen[3] = 1;
    drive();
    n_lastcyc = 0;
    run("sb_done", 100);
    chk("sb_ngnt", 64'(gq.size()), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sb_gnt%0d", i), gat(i), 8);
      chk($sformatf("sb_beat%0d", i), lgat(i), 64'(ent(3, i, 0, 1)));
    end
    chk("sb_lastcyc", 64'(n_lastcyc), 3);

    // port 0 completes, then reset lands inside a port 1 packet
    clr();
    npk[0] = 1; plen[0] = 1;
    drive();
    run("ar_pre", 50);
    clr();
    npk[1] = 1; plen[1] = 6;
    drive();
    done = 1'b0;
    n = 0;
    while ((pending() || busy) && n < 200) begin
      step();
      n++;
      if (!done && bt[1] == 3) begin
        done = 1'b1;
        resetn = 1'b0;
        #1;
        chk("ar_tvalid", 64'(p_tvalid), 0);
        chk("ar_tlast", 64'(p_tlast), 0);
        chk("ar_tdata", 64'(p_tdata), 0);
        chk("ar_tkeep", 64'(p_tkeep), 0);
        chk("ar_grant", 64'(grant), 0);
        chk("ar_busy", 64'(busy), 0);
        chk("ar_tready", 64'(s_tready), 0);
        clr();
      end
    end
    chk("ar_hit", 64'(done), 1);
    step();
    step();
    resetn = 1'b1;
    clr();
    npk[0] = 1; plen[0] = 1;
    npk[1] = 1; plen[1] = 1;
    drive();
    run("ar_done", 100);
    chk("ar_gnt0", gat(0), 1);
    chk("ar_gnt1", gat(1), 2);
    chk("ar_beat0", lgat(0), 64'(ent(0, 0, 0, 1)));
    chk("ar_beat1", lgat(1), 64'(ent(1, 0, 0, 1)));

    // granted port pauses for 3 cycles mid-packet
    clr();
    npk[1] = 1; plen[1] = 4;
    drive();
    en = 1'b0;
    hc = 0;
    n = 0;
    while ((pending() || busy) && n < 200) begin
      step();
      n++;
      if (hc > 0) begin
        chk($sformatf("gap_gnt%0d", hc), 64'(grant), 2);
        hc--;
        if (hc == 0) begin
          chk("gap_nobeat", 64'(lg.size()), 1);
          hold[1] = 1'b0;
          drive();
        end
      end else if (!en && bt[1] == 1) begin
        en = 1'b1;
        hc = 3;
        hold[1] = 1'b1;
        drive();
      end
    end
    chk("gap_done", 64'(n < 200), 1);
    chk("gap_nbeat", 64'(lg.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("gap_beat%0d", i), lgat(i), 64'(ent(1, 0, i, 4)));

    chk("glb_unstable", 64'(n_unstable), 0);
    chk("glb_leak", 64'(n_leak), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
